opll_write_sequencer: RTL and testbench
=======================================

# opll_write_sequencer

Host-side register-write sequencer placed directly upstream of the OPLL core's bus pins (D, A0, CS, WR). It accepts (address, data) register-write requests over a valid/ready handshake and buffers them in a small FIFO. Each request is replayed as an address-phase and a data-phase bus cycle, with the strobe width and post-write wait times the YM2413 requires. The host never has to count master clocks; the core sees only well-formed writes.

## Interface
- `FIFO_DEPTH`, default 4: request FIFO entries. Must be a power of two, ≥2.
- `PULSE_LEN`, default 4: cycles CS/WR are held asserted per phase. Range 1..255.
- `ADDR_WAIT`, default 12: idle cycles after the address strobe. Range 0..255.
- `DATA_WAIT`, default 84: idle cycles after the data strobe. Range 0..255.

Ports:
- `clk`, in, 1: master clock, same clock as the OPLL core (phiM).
- `rst_n`, in, 1: asynchronous active-low reset.
- `i_wr_valid`, in, 1: request present.
- `i_wr_addr`, in, 8: OPLL register address.
- `i_wr_data`, in, 8: register value.
- `o_wr_ready`, out, 1: FIFO can accept a request; equals !full.
- `o_D`, out, 8: bus data to the core.
- `o_A0`, out, 1: 0 = address phase, 1 = data phase.
- `o_CS`, out, 1: chip select, active high; the core-side wrapper inverts it.
- `o_WR`, out, 1: write strobe, active high.
- `o_busy`, out, 1: high when the FIFO is non-empty or the FSM is not IDLE.
- `o_level`, out, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: `i_wr_valid && o_wr_ready` at a rising edge writes {addr, data} at the write pointer. Pointers wrap modulo FIFO_DEPTH. Full and empty are derived from pointers that are one bit wider than the index.
- When full, `o_wr_ready` = 0 and any push is ignored. This holds even when a pop happens in the same cycle; there is no combinational ready-from-pop path.
- A push and a pop in the same cycle (not full, not empty) leave `o_level` unchanged.
- The FSM has 7 states: IDLE, A_SETUP, A_STROBE, A_WAIT, D_SETUP, D_STROBE, D_WAIT.
  - IDLE: if the FIFO is non-empty, pop the head into an entry register and go to A_SETUP.
  - A_SETUP (1 cycle): `o_A0`=0, `o_D`=addr. Go to A_STROBE.
  - A_STROBE (PULSE_LEN cycles): `o_CS`=`o_WR`=1; A0 and D held. Go to A_WAIT, or to D_SETUP if ADDR_WAIT=0.
  - A_WAIT (ADDR_WAIT cycles): strobes low; A0 and D held. Go to D_SETUP.
  - D_SETUP (1 cycle): `o_A0`=1, `o_D`=data. Go to D_STROBE.
  - D_STROBE (PULSE_LEN cycles): strobes high; A0 and D held.
  - D_WAIT (DATA_WAIT cycles): strobes low; A0 and D held. Go to IDLE, or to IDLE directly from D_STROBE if DATA_WAIT=0.
- In IDLE: `o_D`=0, `o_A0`=0, `o_CS`=0, `o_WR`=0.
- A single 8-bit down-counter times the STROBE and WAIT states. It is loaded with N−1 on entry; the state exits when the counter is 0.
- All bus outputs are registered; there are no combinational paths from inputs to bus outputs.
- `o_CS` and `o_WR` are always equal. Neither toggles while A0 or D is changing: D and A0 change only on SETUP entry and on the return to IDLE.

## Timing
- Reset (async assert): FIFO empty, pointers 0, FSM IDLE, counter 0. `o_D`=0, `o_A0`=0, `o_CS`=0, `o_WR`=0, `o_busy`=0, `o_level`=0, `o_wr_ready`=1. Reset release is synchronous to `clk`.
- Reset asserted mid-write drops the strobes immediately and discards the in-flight entry and all queued entries.
- Latency, with the push taken at edge E:
  - `o_level` and `o_busy` update after E.
  - The FSM pops at edge E+1; A0 and D are valid after E+1.
  - `o_CS`/`o_WR` rise after E+2.
- Bus cycles per request, IDLE to IDLE: 2 + 2·PULSE_LEN + ADDR_WAIT + DATA_WAIT. With the defaults this is 106.
- The FSM spends exactly 1 cycle in IDLE between back-to-back requests, so the period is the request length + 1 (107 cycles with the defaults).

## Test plan
- **Single write.** Push (0x10, 0x55) with defaults.
  - `o_A0`=0 and `o_D`=0x10 appear 1 cycle before CS/WR, which are high for 4 cycles.
  - 12 idle cycles follow. Then `o_A0`=1 and `o_D`=0x55, then 4 strobe cycles, then 84 idle cycles.
  - `o_busy` falls 107 cycles after the push edge.
- **Back-to-back with full FIFO.** Hold valid high with 6 requests.
  - `o_wr_ready` drops once 4 entries are queued and one is in flight.
  - All 6 writes appear in order, 107 cycles apart.
  - No request is lost or duplicated.
- **Push at full with a same-cycle pop.** The request is not accepted; the host must retry. `o_level` decrements by 1.
- **Reset mid-strobe.** Assert `rst_n`=0 during D_STROBE.
  - CS/WR fall in the same cycle, without waiting for a clock edge.
  - After release: `o_level`=0, `o_busy`=0, and no further bus activity occurs.
- **Zero-wait variant.** ADDR_WAIT=0, DATA_WAIT=0, PULSE_LEN=1.
  - The request takes 4 cycles: A_SETUP, A_STROBE, D_SETUP, D_STROBE.
  - The strobe goes low for the D_SETUP cycle between the two phases.
- **Pointer wrap.** Run 2·FIFO_DEPTH+1 requests with interleaved stalls on `i_wr_valid`. The data order is preserved across pointer wrap, and `o_level` never exceeds FIFO_DEPTH.

Source files
------------

// File: rtl/opll_write_sequencer.sv
// opll_write_sequencer
//
// Buffers host register writes in a small FIFO and replays each one as a
// YM2413-compliant bus transaction: an address phase (A0=0), then a data
// phase (A0=1). Each phase has a one-cycle setup, a PULSE_LEN-cycle CS/WR
// strobe and a post-strobe wait. Every bus output is registered.
//
// Ports:
//   clk, rst_n             master clock (phiM), async active-low reset
//   i_wr_valid/addr/data   write request (valid/ready handshake)
//   o_wr_ready             FIFO not full
//   o_D, o_A0, o_CS, o_WR  registered bus to the core (CS/WR active high)
//   o_busy                 FIFO non-empty or a transaction in progress
//   o_level                FIFO occupancy
module opll_write_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_LEN  = 4,
  parameter int ADDR_WAIT  = 12,
  parameter int DATA_WAIT  = 84
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_wr_valid,
  input  logic [7:0]                    i_wr_addr,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_wr_ready,
  output logic [7:0]                    o_D,
  output logic                          o_A0,
  output logic                          o_CS,
  output logic                          o_WR,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Counter reload values. A zero wait never uses its reload value because
  // the corresponding wait state is skipped.
  localparam logic [7:0] PULSE_M1 = 8'(PULSE_LEN - 1);
  localparam logic [7:0] AWAIT_M1 = 8'(ADDR_WAIT - 1);
  localparam logic [7:0] DWAIT_M1 = 8'(DATA_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_WAIT,
    D_SETUP,
    D_STROBE,
    D_WAIT
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  entry_data;
  logic        strobe;

  logic [15:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic [15:0] head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready depends only on registered pointers, so a same-cycle pop never
  // frees a slot for a push at full.
  assign push = i_wr_valid && !full;
  assign pop  = (state == IDLE) && !empty;
  assign head = mem[rd_ptr[AW-1:0]];

  assign o_wr_ready = !full;
  assign o_level    = wr_ptr - rd_ptr;
  assign o_busy     = !empty || (state != IDLE);
  assign o_CS       = strobe;
  assign o_WR       = strobe;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_wr_addr, i_wr_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Bus outputs are assigned on the transition into the state that shows
  // them, so they are valid for the whole state. D and A0 only change on
  // SETUP entry and on the return to IDLE, never while the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      entry_data <= '0;
      strobe     <= 1'b0;
      o_D        <= '0;
      o_A0       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          strobe <= 1'b0;
          o_A0   <= 1'b0;
          if (!empty) begin
            o_D        <= head[15:8];
            entry_data <= head[7:0];
            state      <= A_SETUP;
          end else begin
            o_D <= '0;
          end
        end
        A_SETUP: begin
          strobe <= 1'b1;
          cnt    <= PULSE_M1;
          state  <= A_STROBE;
        end
        A_STROBE: begin
          if (cnt == 8'd0) begin
            strobe <= 1'b0;
            if (ADDR_WAIT == 0) begin
              o_A0  <= 1'b1;
              o_D   <= entry_data;
              state <= D_SETUP;
            end else begin
              cnt   <= AWAIT_M1;
              state <= A_WAIT;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        A_WAIT: begin
          if (cnt == 8'd0) begin
            o_A0  <= 1'b1;
            o_D   <= entry_data;
            state <= D_SETUP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        D_SETUP: begin
          strobe <= 1'b1;
          cnt    <= PULSE_M1;
          state  <= D_STROBE;
        end
        D_STROBE: begin
          if (cnt == 8'd0) begin
            strobe <= 1'b0;
            if (DATA_WAIT == 0) begin
              o_A0  <= 1'b0;
              o_D   <= '0;
              state <= IDLE;
            end else begin
              cnt   <= DWAIT_M1;
              state <= D_WAIT;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        D_WAIT: begin
          if (cnt == 8'd0) begin
            o_A0  <= 1'b0;
            o_D   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          strobe <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opll_write_sequencer.sv
module tb_opll_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wrValid;
  logic [7:0] wrAddr;
  logic [7:0] wrData;
  logic       wrReady;
  logic [7:0] busD;
  logic       busA0;
  logic       busCs;
  logic       busWr;
  logic       busy;
  logic [2:0] level;

  logic       zValid;
  logic [7:0] zAddr;
  logic [7:0] zData;
  logic       zReady;
  logic [7:0] zD;
  logic       zA0;
  logic       zCs;
  logic       zWr;
  logic       zBusy;
  logic [2:0] zLevel;

  int testsRun  = 0;
  int failCount = 0;

  logic [15:0] expQ[$];
  int          writeStamps[$];
  int          writeCount = 0;
  int          cycle      = 0;
  int          maxLevel   = 0;
  logic        prevCs     = 1'b0;
  logic [7:0]  capAddr    = 8'h00;

  always #5 clk = ~clk;

  opll_write_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(wrValid), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .o_wr_ready(wrReady), .o_D(busD), .o_A0(busA0), .o_CS(busCs), .o_WR(busWr),
    .o_busy(busy), .o_level(level)
  );

  opll_write_sequencer #(.FIFO_DEPTH(4), .PULSE_LEN(1), .ADDR_WAIT(0), .DATA_WAIT(0)) zdut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(zValid), .i_wr_addr(zAddr), .i_wr_data(zData),
    .o_wr_ready(zReady), .o_D(zD), .o_A0(zA0), .o_CS(zCs), .o_WR(zWr),
    .o_busy(zBusy), .o_level(zLevel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {cs, wr, a0, d} k cycles after the push edge of a lone request.
  function automatic logic [10:0] busModel(input int k, input logic [7:0] a, input logic [7:0] d,
                                           input int p, input int aw, input int dw);
    int aStrEnd  = 1 + p;
    int aWaitEnd = aStrEnd + aw;
    int dSet     = aWaitEnd + 1;
    int dStrEnd  = dSet + p;
    int dWaitEnd = dStrEnd + dw;
    if (k == 1)             return {3'b000, a};
    else if (k <= aStrEnd)  return {3'b110, a};
    else if (k <= aWaitEnd) return {3'b000, a};
    else if (k == dSet)     return {3'b001, d};
    else if (k <= dStrEnd)  return {3'b111, d};
    else if (k <= dWaitEnd) return {3'b001, d};
    else                    return 11'd0;
  endfunction

  // Scoreboard monitor: address captured on the address-phase strobe rise,
  // full write compared on the data-phase strobe rise.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (int'(level) > maxLevel) maxLevel = int'(level);
    if (!rst_n) begin
      prevCs = 1'b0;
    end else begin
      if (busCs && !prevCs) begin
        checkOutput("wr with cs", 32'(busWr), 32'd1);
        if (!busA0) begin
          capAddr = busD;
        end else begin
          writeCount++;
          writeStamps.push_back(cycle);
          if (expQ.size() == 0) begin
            checkOutput("unexpected write", 32'(writeCount), 32'd0);
          end else begin
            logic [15:0] e;
            e = expQ.pop_front();
            checkOutput("write addr", 32'(capAddr), 32'(e[15:8]));
            checkOutput("write data", 32'(busD), 32'(e[7:0]));
          end
        end
      end
      prevCs = busCs;
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d);
    int guard = 0;
    wrValid = 1'b1;
    wrAddr  = a;
    wrData  = d;
    while (!wrReady && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!wrReady) begin
      checkOutput("ready timeout", 32'(wrReady), 32'd1);
    end else begin
      @(posedge clk); #1;
      expQ.push_back({a, d});
    end
    wrValid = 1'b0;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle timeout", 32'(busy), 32'd0);
  endtask

  task automatic traceRequest(input bit useZ, input logic [7:0] a, input logic [7:0] d,
                              input int p, input int aw, input int dw);
    int last = 2 + 2 * p + aw + dw;
    for (int k = 1; k <= last + 1; k++) begin
      logic [10:0] got;
      @(posedge clk); #1;
      got = useZ ? {zCs, zWr, zA0, zD} : {busCs, busWr, busA0, busD};
      checkOutput($sformatf("bus k=%0d", k), 32'(got), 32'(busModel(k, a, d, p, aw, dw)));
      if (k >= last) begin
        checkOutput($sformatf("busy k=%0d", k), 32'(useZ ? zBusy : busy), 32'(k == last));
      end
    end
  endtask

  initial begin
    int base;
    int guard;
    int csSeen;
    rst_n   = 1'b0;
    wrValid = 1'b0; wrAddr = '0; wrData = '0;
    zValid  = 1'b0; zAddr  = '0; zData  = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset bus", 32'({busCs, busWr, busA0, busD}), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset ready", 32'(wrReady), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write with default timing
    applyStimulus(8'h10, 8'h55);
    checkOutput("single level", 32'(level), 32'd1);
    checkOutput("single busy", 32'(busy), 32'd1);
    traceRequest(1'b0, 8'h10, 8'h55, 4, 12, 84);

    // Back-to-back burst filling the FIFO, then push at full with same-cycle pop
    writeStamps.delete();
    for (int i = 0; i < 5; i++) applyStimulus(8'h20 + 8'(i), 8'hA0 + 8'(i));
    checkOutput("full level", 32'(level), 32'd4);
    checkOutput("full ready", 32'(wrReady), 32'd0);
    wrValid = 1'b1; wrAddr = 8'h25; wrData = 8'hA5;
    guard = 0;
    while (level == 3'd4 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("level after pop at full", 32'(level), 32'd3);
    checkOutput("ready after pop at full", 32'(wrReady), 32'd1);
    applyStimulus(8'h25, 8'hA5);
    checkOutput("level after retry", 32'(level), 32'd4);
    waitIdle(1000);
    checkOutput("burst writes", 32'(writeStamps.size()), 32'd6);
    for (int i = 0; i + 1 < writeStamps.size(); i++) begin
      checkOutput($sformatf("burst period %0d", i), 32'(writeStamps[i+1] - writeStamps[i]), 32'd107);
    end
    checkOutput("burst scoreboard empty", 32'(expQ.size()), 32'd0);

    // Reset during the data strobe
    applyStimulus(8'h30, 8'h01);
    applyStimulus(8'h31, 8'h02);
    applyStimulus(8'h32, 8'h03);
    guard = 0;
    while (!(busCs && busA0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reached d strobe", 32'(busCs && busA0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async cs drop", 32'({busCs, busWr}), 32'd0);
    expQ.delete();
    @(negedge clk) rst_n = 1'b1;
    csSeen = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (busCs) csSeen++;
    end
    checkOutput("post reset strobes", 32'(csSeen), 32'd0);
    checkOutput("post reset level", 32'(level), 32'd0);
    checkOutput("post reset busy", 32'(busy), 32'd0);

    // Zero-wait variant
    zValid = 1'b1; zAddr = 8'h0E; zData = 8'h3C;
    @(posedge clk); #1;
    zValid = 1'b0;
    checkOutput("zero level", 32'(zLevel), 32'd1);
    traceRequest(1'b1, 8'h0E, 8'h3C, 1, 0, 0);

    // Pointer wrap with stalls on valid
    base = writeCount;
    maxLevel = 0;
    for (int i = 0; i < 9; i++) begin
      int stall;
      applyStimulus(8'h40 + 8'(i), 8'hC0 ^ 8'(i * 7));
      stall = ($urandom_range(0, 2) == 0) ? 150 : int'($urandom_range(0, 5));
      repeat (stall) @(posedge clk);
      #1;
    end
    waitIdle(2000);
    checkOutput("wrap writes", 32'(writeCount - base), 32'd9);
    checkOutput("wrap max level ok", 32'(maxLevel <= 4), 32'd1);
    checkOutput("wrap scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
